// File: rtl/ofm_writeback_packer.sv
// Captures a full OFM result (all lanes valid) and streams it to the next-layer RAM in BEAT_LANES-wide words.
// Optional macro OFM_RELU_EN clamps negative signed lanes to zero at capture.
module ofm_writeback_packer #(
  parameter int LANES      = 16,
  parameter int DATA_W     = 8,
  parameter int BEAT_LANES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES*DATA_W-1:0]      ofm_data_in,
  input  logic [LANES-1:0]             ofm_valid_in,
  output logic                         ofm_ready,
  input  logic                         layer_start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            num_words,
  output logic                         wr_en_next,
  output logic [ADDR_W-1:0]            addr_ram_next_wr,
  output logic [BEAT_LANES*DATA_W-1:0] data_ram_next_wr,
  input  logic                         wr_ready,
  output logic                         layer_done
);

  localparam int BEATS  = LANES / BEAT_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = BEAT_LANES * DATA_W;
  localparam int HOLD_W = LANES * DATA_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [ADDR_W-1:0]   count, count_nxt;
  logic [HOLD_W-1:0]   hold_p0, hold_nxt;

  function automatic logic [DATA_W-1:0] relu_lane(input logic [DATA_W-1:0] x);
`ifdef OFM_RELU_EN
    logic signed [DATA_W-1:0] s;
    s = signed'(x);
    return (s < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [HOLD_W-1:0] capture_lanes(input logic [HOLD_W-1:0] d);
    logic [HOLD_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[i*DATA_W +: DATA_W] = relu_lane(d[i*DATA_W +: DATA_W]);
    end
    return r;
  endfunction

  assign addr_ram_next_wr = addr;
  assign data_ram_next_wr = hold_p0[int'(beat)*WORD_W +: WORD_W];

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    addr_nxt   = addr;
    count_nxt  = count;
    hold_nxt   = hold_p0;
    ofm_ready  = 1'b0;
    wr_en_next = 1'b0;
    layer_done = 1'b0;
    case (state)
      IDLE: begin
        ofm_ready = 1'b1;
        if (layer_start) begin
          addr_nxt  = base_addr;
          count_nxt = '0;
        end
        if (&ofm_valid_in) begin
          hold_nxt  = capture_lanes(ofm_data_in);
          beat_nxt  = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        wr_en_next = 1'b1;
        if (wr_ready) begin
          addr_nxt  = addr + 1'b1;
          count_nxt = count + 1'b1;
          beat_nxt  = beat + 1'b1;
          // The word limit is only evaluated at a result boundary so a result is never split.
          if (beat == LAST_BEAT) begin
            beat_nxt = '0;
            if ((num_words != '0) && (count_nxt >= num_words)) begin
              state_nxt = DONE;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DONE: begin
        layer_done = 1'b1;
        if (layer_start) begin
          addr_nxt  = base_addr;
          count_nxt = '0;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: state, beat pointer, address/count and holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= '0;
      addr    <= '0;
      count   <= '0;
      hold_p0 <= '0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      addr    <= addr_nxt;
      count   <= count_nxt;
      hold_p0 <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Randomized bench for ofm_writeback_packer with a layer-level write-list reference model.
module tb_ofm_writeback_packer;
  localparam int LANES = 16, DATA_W = 8, BEAT_LANES = 4, ADDR_W = 32;
  localparam int IN_W = LANES * DATA_W;
  localparam int WORD_W = BEAT_LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IN_W-1:0]   ofm_data_in = '0;
  logic [LANES-1:0]  ofm_valid_in = '0;
  logic              ofm_ready;
  logic              layer_start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic              wr_en_next;
  logic [ADDR_W-1:0] addr_ram_next_wr;
  logic [WORD_W-1:0] data_ram_next_wr;
  logic              wr_ready;
  logic              layer_done;

  logic rand_mode = 1'b0, forced_ready = 1'b1, rnd_bit = 1'b1;
  assign wr_ready = rand_mode ? rnd_bit : forced_ready;

  ofm_writeback_packer #(.LANES(LANES), .DATA_W(DATA_W), .BEAT_LANES(BEAT_LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ofm_data_in(ofm_data_in), .ofm_valid_in(ofm_valid_in),
    .ofm_ready(ofm_ready), .layer_start(layer_start), .base_addr(base_addr), .num_words(num_words),
    .wr_en_next(wr_en_next), .addr_ram_next_wr(addr_ram_next_wr), .data_ram_next_wr(data_ram_next_wr),
    .wr_ready(wr_ready), .layer_done(layer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

  // Observed accepted writes and layer_done pulses, sampled mid-cycle
  int          cyc = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          done_cyc[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_next === 1'b1 && wr_ready === 1'b1) begin
      obs_addr.push_back(addr_ram_next_wr);
      obs_data.push_back(data_ram_next_wr);
      obs_cyc.push_back(cyc);
    end
    if (layer_done === 1'b1) done_cyc.push_back(cyc);
  end

  // Reference model: expected write list built from captured results
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] cur_addr = '0;
  int n_checks = 0, n_pass = 0;

  function automatic logic [7:0] ref_lane(input logic [7:0] v);
`ifdef OFM_RELU_EN
    if ($signed(v) < 0) return 8'h00;
`endif
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [IN_W-1:0] r, input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w = w | (32'(ref_lane(r[(k*4+j)*8 +: 8])) << (8*j));
    return w;
  endfunction

  function automatic logic [IN_W-1:0] rand_result();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_layer_start(input logic [31:0] b, input logic [31:0] nw);
    base_addr = b; num_words = nw; layer_start = 1'b1;
    step();
    layer_start = 1'b0;
    cur_addr = b;
  endtask

  task automatic drive_result(input logic [IN_W-1:0] d);
    logic got;
    got = 1'b0;
    ofm_data_in = d; ofm_valid_in = '1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ofm_ready === 1'b1) begin got = 1'b1; break; end
    end
    step();
    ofm_valid_in = '0; ofm_data_in = rand_result();
    n_checks++;
    if (!got) $display("FAIL capture_timeout: ofm_ready never 1, required 1");
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back(cur_addr + 32'(k));
      exp_data.push_back(ref_word(d, k));
    end
    cur_addr = cur_addr + 32'd4;
  endtask

  task automatic wait_writes(input int n);
    for (int i = 0; i < n; i++) begin
      if (obs_addr.size() >= exp_addr.size()) break;
      step();
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; forced_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++; if (wr_en_next !== 1'b0) $display("FAIL rst_wr_en: got %b required 0", wr_en_next); else n_pass++;
    n_checks++; if (addr_ram_next_wr !== 32'h0) $display("FAIL rst_addr: got %h required 0", addr_ram_next_wr); else n_pass++;
    n_checks++; if (data_ram_next_wr !== 32'h0) $display("FAIL rst_data: got %h required 0", data_ram_next_wr); else n_pass++;
    n_checks++; if (layer_done !== 1'b0) $display("FAIL rst_done: got %b required 0", layer_done); else n_pass++;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ofm_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", ofm_ready); else n_pass++;
    step();
  endtask

  task automatic test_basic();
    int ws, ds;
    logic [IN_W-1:0] d;
    ws = obs_addr.size(); ds = done_cyc.size();
    for (int i = 0; i < LANES; i++) d[i*8 +: 8] = 8'(i);
    base_addr = 32'h100; num_words = 32'd4; cur_addr = 32'h100;
    layer_start = 1'b1;
    drive_result(d);
    layer_start = 1'b0;
    wait_writes(50);
    n_checks++; if (obs_addr.size() - ws !== 4) $display("FAIL basic_count: got %0d required 4", obs_addr.size() - ws); else n_pass++;
    for (int i = ws; i < ws + 4 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("FAIL basic_write%0d: got %h/%h required %h/%h", i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (done_cyc.size() - ds !== 1) $display("FAIL basic_done_count: got %0d required 1", done_cyc.size() - ds); else n_pass++;
    if (done_cyc.size() > ds && obs_cyc.size() >= ws + 4) begin
      n_checks++;
      if (done_cyc[ds] !== obs_cyc[ws+3] + 1) $display("FAIL basic_done_time: got %0d required %0d", done_cyc[ds], obs_cyc[ws+3] + 1);
      else n_pass++;
    end
  endtask

  task automatic test_partial();
    int ws;
    ws = obs_addr.size();
    for (int i = 0; i < 10; i++) begin
      ofm_valid_in = 16'h7FFF; ofm_data_in = rand_result();
      @(negedge clk);
      n_checks++; if (ofm_ready !== 1'b1) $display("FAIL partial_ready%0d: got %b required 1", i, ofm_ready); else n_pass++;
      step();
    end
    ofm_valid_in = '0;
    repeat (5) step();
    n_checks++; if (obs_addr.size() !== ws) $display("FAIL partial_writes: got %0d required 0", obs_addr.size() - ws); else n_pass++;
  endtask

  task automatic test_stall();
    int ws;
    ws = obs_addr.size();
    do_layer_start($urandom, 32'd0);
    forced_ready = 1'b1;
    drive_result(rand_result());
    step();
    forced_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // A layer_start while sending must not disturb the address stream.
      layer_start = (i == 0); base_addr = 32'hDEAD0000;
      @(negedge clk);
      n_checks++;
      if (wr_en_next !== 1'b1 || addr_ram_next_wr !== exp_addr[ws+1] || data_ram_next_wr !== exp_data[ws+1])
        $display("FAIL stall_hold%0d: got %b/%h/%h required 1/%h/%h", i, wr_en_next, addr_ram_next_wr, data_ram_next_wr, exp_addr[ws+1], exp_data[ws+1]);
      else n_pass++;
      step();
    end
    layer_start = 1'b0;
    forced_ready = 1'b1;
    wait_writes(50);
    n_checks++; if (obs_addr.size() - ws !== 4) $display("FAIL stall_count: got %0d required 4", obs_addr.size() - ws); else n_pass++;
    for (int i = ws; i < ws + 4 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("FAIL stall_write%0d: got %h/%h required %h/%h", i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_relu();
    int ws;
    logic [IN_W-1:0] d;
    logic [15:0] want;
`ifdef OFM_RELU_EN
    want = 16'h7F00;
`else
    want = 16'h7F80;
`endif
    ws = obs_addr.size();
    d = rand_result(); d[7:0] = 8'h80; d[15:8] = 8'h7F;
    do_layer_start(32'h40, 32'd0);
    drive_result(d);
    wait_writes(50);
    n_checks++; if (obs_addr.size() - ws !== 4) $display("FAIL relu_count: got %0d required 4", obs_addr.size() - ws); else n_pass++;
    if (obs_data.size() > ws) begin
      n_checks++; if (obs_data[ws][15:0] !== want) $display("FAIL relu_low: got %h required %h", obs_data[ws][15:0], want); else n_pass++;
    end
    for (int i = ws; i < ws + 4 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("FAIL relu_write%0d: got %h/%h required %h/%h", i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int ws, ds;
    ws = obs_addr.size(); ds = done_cyc.size();
    do_layer_start(32'hFFFF_FFFE, 32'd0);
    rand_mode = 1'b1;
    drive_result(rand_result());
    drive_result(rand_result());
    wait_writes(300);
    rand_mode = 1'b0;
    n_checks++; if (obs_addr.size() - ws !== 8) $display("FAIL wrap_count: got %0d required 8", obs_addr.size() - ws); else n_pass++;
    for (int i = ws; i < ws + 8 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("FAIL wrap_write%0d: got %h/%h required %h/%h", i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
    n_checks++; if (done_cyc.size() !== ds) $display("FAIL wrap_no_done: got %0d pulses required 0", done_cyc.size() - ds); else n_pass++;
  endtask

  task automatic test_random_layers();
    int ws, ds, nw, nres;
    logic [15:0] v;
    for (int layer = 0; layer < 4; layer++) begin
      ws = obs_addr.size(); ds = done_cyc.size();
      case ($urandom_range(0, 3))
        0: nw = 4;
        1: nw = 6;
        2: nw = 8;
        default: nw = 12;
      endcase
      nres = (nw + 3) / 4;
      do_layer_start($urandom, 32'(nw));
      rand_mode = 1'b1;
      for (int r = 0; r < nres; r++) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          v = 16'($urandom);
          if (v == 16'hFFFF) v = 16'h0;
          ofm_valid_in = v; ofm_data_in = rand_result();
          step();
        end
        drive_result(rand_result());
      end
      wait_writes(400);
      rand_mode = 1'b0;
      n_checks++;
      if (obs_addr.size() - ws !== nres * 4) $display("FAIL rnd%0d_count: got %0d required %0d", layer, obs_addr.size() - ws, nres * 4);
      else n_pass++;
      for (int i = ws; i < ws + nres * 4 && i < obs_addr.size(); i++) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
          $display("FAIL rnd%0d_write%0d: got %h/%h required %h/%h", layer, i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
      n_checks++; if (done_cyc.size() - ds !== 1) $display("FAIL rnd%0d_done: got %0d pulses required 1", layer, done_cyc.size() - ds); else n_pass++;
      if (done_cyc.size() > ds && obs_cyc.size() >= ws + nres * 4) begin
        n_checks++;
        if (done_cyc[ds] !== obs_cyc[ws + nres*4 - 1] + 1)
          $display("FAIL rnd%0d_done_time: got %0d required %0d", layer, done_cyc[ds], obs_cyc[ws + nres*4 - 1] + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int ws;
    ws = obs_addr.size();
    forced_ready = 1'b1;
    do_layer_start(32'h200, 32'd0);
    drive_result(rand_result());
    step();
    step();
    forced_ready = 1'b0; rst_n = 1'b0;
    step();
    @(negedge clk);
    n_checks++; if (wr_en_next !== 1'b0) $display("FAIL midrst_wr_en: got %b required 0", wr_en_next); else n_pass++;
    n_checks++; if (addr_ram_next_wr !== 32'h0) $display("FAIL midrst_addr: got %h required 0", addr_ram_next_wr); else n_pass++;
    step();
    rst_n = 1'b1; forced_ready = 1'b1;
    repeat (10) step();
    void'(exp_addr.pop_back()); void'(exp_addr.pop_back());
    void'(exp_data.pop_back()); void'(exp_data.pop_back());
    n_checks++; if (obs_addr.size() - ws !== 2) $display("FAIL midrst_count: got %0d required 2", obs_addr.size() - ws); else n_pass++;
    for (int i = ws; i < ws + 2 && i < obs_addr.size(); i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
        $display("FAIL midrst_write%0d: got %h/%h required %h/%h", i - ws, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_stall();
    test_relu();
    test_wrap();
    test_random_layers();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/ofm_writeback_packer.md
OFM_WRITEBACK_PACKER -- requirements
Module: ofm_writeback_packer

Interface
REQ-001 Parameter LANES, default 16: number of OFM lanes delivered per compute result.
REQ-002 Parameter DATA_W, default 8: bits per lane.
REQ-003 Parameter BEAT_LANES, default 4: lanes packed per RAM word; beats per result = LANES/BEAT_LANES = 4.
REQ-004 Parameter ADDR_W, default 32: RAM address width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 ofm_data_in  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
REQ-008 ofm_valid_in  in  LANES  per-lane valid.
REQ-009 ofm_ready  out  1  packer can capture a result.
REQ-010 layer_start  in  1  one-cycle pulse: load base address, clear word count.
REQ-011 base_addr  in  ADDR_W  first write address of layer.
REQ-012 num_words  in  ADDR_W  words to write in layer; 0 = unlimited.
REQ-013 wr_en_next  out  1  write request to next-layer RAM.
REQ-014 addr_ram_next_wr  out  ADDR_W  write address.
REQ-015 data_ram_next_wr  out  BEAT_LANES*DATA_W  write data.
REQ-016 wr_ready  in  1  RAM accepts write this cycle.
REQ-017 layer_done  out  1  one-cycle pulse after last word of layer accepted.

Function
REQ-018 FSM states SHALL be IDLE, SEND, DONE.
REQ-019 IDLE: ofm_ready=1; capture SHALL occur only when ofm_valid_in is all ones, latching ofm_data_in into a holding register and going to SEND with beat=0.
REQ-020 Partial valid (any lane bit 0) SHALL be ignored; no capture, no state change.
REQ-021 SEND: ofm_ready=0, wr_en_next=1, data = holding lanes [beat*4 .. beat*4+3], lowest lane in LSBs; first wr_en_next one cycle after capture edge.
REQ-022 Beat, address, word count SHALL advance only on cycles where wr_en_next and wr_ready are both 1; outputs held stable otherwise.
REQ-023 addr_ram_next_wr SHALL increment by 1 per accepted word, wrapping modulo 2^ADDR_W.
REQ-024 After beat 3 accepted: go DONE if num_words!=0 and word count reaches num_words, else IDLE.
REQ-025 Word limit reached mid-result SHALL still complete all 4 beats of that result before DONE.
REQ-026 DONE: layer_done=1 for exactly one cycle, ofm_ready=0, then IDLE; word count held until next layer_start.
REQ-027 layer_start SHALL load address=base_addr and count=0 only in IDLE or DONE; in SEND it SHALL be ignored.
REQ-028 layer_start coincident with a full-valid capture in IDLE: both take effect; first beat uses base_addr.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, beat=0, count=0, addr_ram_next_wr=0, data_ram_next_wr=0, wr_en_next=0, layer_done=0, holding register=0; ofm_ready=1 after release.
REQ-030 Reset mid-SEND SHALL abandon the result with no further writes.

Configuration
REQ-031 Macro OFM_RELU_EN defined: each lane treated as signed, negative values replaced by 0 at capture; undefined: lanes captured unmodified.

Verification
REQ-032 Reset, layer_start base=0x100, num_words=4, all valid, lanes i=i, wr_ready=1 -> 4 writes addr 0x100..0x103, data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, layer_done pulse next cycle.
REQ-033 valid=0x7FFF for 10 cycles -> no writes, ofm_ready stays 1.
REQ-034 wr_ready low 3 cycles on beat 1 -> wr_en_next, addr, data held; beat 1 written once.
REQ-035 base=0xFFFFFFFE, num_words=0, two results -> addresses wrap FFFFFFFE, FFFFFFFF, 0, 1, ...; no layer_done.
REQ-036 OFM_RELU_EN defined, lane 0 = 0x80, lane 1 = 0x7F -> first word low bytes 0x7F00; undefined -> 0x7F80.
REQ-037 rst_n low during beat 2 -> wr_en_next=0 next cycle, addr=0, no remaining beats.
